fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// FETCH_MISALIGN_CHECK_EN adds the HALT state used after a misaligned redirect.
package fetch_unit_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    ST_HALT
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait, hold for decode, drop on redirect.
// FETCH_MISALIGN_CHECK_EN enables the sticky misalign flag and HALT on misaligned redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [XLEN-1:0]   id_pc,
  input  logic              pc_branch,
  input  logic [XLEN-1:0]   target_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              req_valid_q, req_valid_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              id_valid_q, id_valid_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic              redirect;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  // Next-state, PC and instruction-register update; redirect outranks every other event.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    id_inst_d = id_inst_q;
    id_pc_d   = id_pc_q;
    redirect  = pc_branch;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
    if (state_q == ST_HALT) redirect = 1'b0;
`endif

    case (state_q)
      ST_REQ: begin
        if (redirect)            state_d = imem_req_ready ? ST_DROP : ST_REQ;
        else if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          id_inst_d = imem_rsp_data;
          id_pc_d   = pc_q;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (id_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (!redirect && imem_rsp_valid) state_d = ST_REQ;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_REQ;
    endcase

    if (redirect) pc_d = target_pc & ~XLEN'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
    // A misaligned target freezes fetch; any owed response lands in HALT and is ignored.
    if (redirect && (target_pc[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
      pc_d       = pc_q;
      state_d    = ST_HALT;
    end
`endif

    req_valid_d = (state_d == ST_REQ);
    req_addr_d  = pc_d;
    id_valid_d  = (state_d == ST_HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b1;
      req_addr_q  <= RESET_PC;
      id_valid_q  <= 1'b0;
      id_inst_q   <= '0;
      id_pc_q     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      id_valid_q  <= id_valid_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign id_valid       = id_valid_q;
  assign id_inst        = id_inst_q;
  assign id_pc          = id_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign       = misalign_q;
`endif

endmodule
